// File: rtl/lcd_bus_driver.sv
// ---------------------------------------------------------------------------
// lcd_bus_driver
// Write-only driver for an HD44780-style character LCD on an 8-bit bus.
// After reset it waits POR_WAIT_CYC cycles and then issues the init commands
// 0x38, 0x0C, 0x06, 0x01. After that it serves three kinds of request:
// clear (0x01), newline (0xC0 / 0x80 depending on the current line) and data
// characters. Each transaction has three phases: RS/DB setup, an E pulse,
// and an execution wait with E low.
//
// Optional feature: define LCD_AUTOWRAP_EN to issue a set-DDRAM command to
// the other line after a character is written at column 15. When it is not
// defined, the column counter rolls over 15 -> 0 and the line stays the same.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   char_in/valid/ready     character stream (accepted when valid && ready)
//   clear_req, newline_req  single-cycle request pulses (dropped while busy)
//   init_done, busy         status
//   lcd_db/rs/rw/e          LCD bus (rw is always 0)
//   cur_line, cur_col       cursor position tracking
//
// The two wait parameters and POR_WAIT_CYC must be >= 2. The last wait
// cycle before a chained command (the next init step or a wrap) is spent in
// an issue state, so chained commands add no extra bus cycles.
// ---------------------------------------------------------------------------
module lcd_bus_driver #(
    parameter int unsigned POR_WAIT_CYC = 2000000,
    parameter int unsigned SETUP_CYC    = 4,
    parameter int unsigned E_PULSE_CYC  = 50,
    parameter int unsigned CMD_WAIT_CYC = 5000,
    parameter int unsigned CLR_WAIT_CYC = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    input  logic       clear_req,
    input  logic       newline_req,
    output logic       init_done,
    output logic       busy,
    output logic [7:0] lcd_db,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       cur_line,
    output logic [3:0] cur_col
);

    localparam logic [2:0] POR_WAIT   = 3'd0;
    localparam logic [2:0] INIT_ISSUE = 3'd1;
    localparam logic [2:0] IDLE       = 3'd2;
    localparam logic [2:0] SETUP      = 3'd3;
    localparam logic [2:0] E_HIGH     = 3'd4;
    localparam logic [2:0] EXEC_WAIT  = 3'd5;
    localparam logic [2:0] WRAP_ISSUE = 3'd6;

    localparam logic [31:0] POR_LAST   = 32'(POR_WAIT_CYC - 2);
    localparam logic [31:0] SETUP_LAST = 32'(SETUP_CYC - 1);
    localparam logic [31:0] E_LAST     = 32'(E_PULSE_CYC - 1);

    // Init command table, indexed by the init step.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    // Command that moves the cursor to the start of the other line.
    function automatic logic [7:0] other_line_cmd(input logic line);
        other_line_cmd = line ? 8'h80 : 8'hC0;
    endfunction

    logic [2:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  init_idx_q, init_idx_d;
    logic        wrap_pend_q, wrap_pend_d;
    logic [7:0]  db_q, db_d;
    logic        rs_q, rs_d;
    logic        e_q, e_d;
    logic        rdy_q, rdy_d;
    logic        init_done_q, init_done_d;
    logic        line_q, line_d;
    logic [3:0]  col_q, col_d;

    logic [31:0] wait_len_s;
    logic [31:0] wait_last_s;
    logic [31:0] issue_last_s;
    logic        chain_s;

    // Wait length follows the command on the bus (clear display is slow).
    always_comb begin
        if (!rs_q && (db_q == 8'h01)) begin
            wait_len_s = 32'(CLR_WAIT_CYC);
        end else begin
            wait_len_s = 32'(CMD_WAIT_CYC);
        end
        wait_last_s  = wait_len_s - 32'd1;
        issue_last_s = wait_len_s - 32'd2;
        chain_s      = wrap_pend_q || (!init_done_q && (init_idx_q != 2'd3));
    end

    // Next-state logic for the transaction sequencer and cursor tracking.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_idx_d  = init_idx_q;
        wrap_pend_d = wrap_pend_q;
        db_d        = db_q;
        rs_d        = rs_q;
        init_done_d = init_done_q;
        line_d      = line_q;
        col_d       = col_q;
        case (state_q)
            POR_WAIT: begin
                init_idx_d = 2'd0;
                if (cnt_q == POR_LAST) begin
                    state_d = INIT_ISSUE;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            INIT_ISSUE: begin
                db_d    = init_cmd(init_idx_q);
                rs_d    = 1'b0;
                cnt_d   = 32'd0;
                state_d = SETUP;
            end
            IDLE: begin
                cnt_d = 32'd0;
                if (init_done_q && clear_req) begin
                    db_d    = 8'h01;
                    rs_d    = 1'b0;
                    line_d  = 1'b0;
                    col_d   = 4'd0;
                    state_d = SETUP;
                end else if (init_done_q && newline_req) begin
                    db_d    = other_line_cmd(line_q);
                    rs_d    = 1'b0;
                    line_d  = ~line_q;
                    col_d   = 4'd0;
                    state_d = SETUP;
                end else if (init_done_q && char_valid) begin
                    db_d    = char_in;
                    rs_d    = 1'b1;
                    state_d = SETUP;
`ifdef LCD_AUTOWRAP_EN
                    // Column stays at 15 until the wrap command is accepted.
                    if (col_q == 4'd15) begin
                        wrap_pend_d = 1'b1;
                    end else begin
                        col_d = col_q + 4'd1;
                    end
`else
                    col_d = col_q + 4'd1;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = E_HIGH;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            E_HIGH: begin
                if (cnt_q == E_LAST) begin
                    state_d = EXEC_WAIT;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            EXEC_WAIT: begin
                // A chained command spends its last wait cycle in the issue state.
                if (chain_s && (cnt_q == issue_last_s)) begin
                    cnt_d = 32'd0;
                    if (wrap_pend_q) begin
                        state_d = WRAP_ISSUE;
                    end else begin
                        state_d    = INIT_ISSUE;
                        init_idx_d = init_idx_q + 2'd1;
                    end
                end else if (!chain_s && (cnt_q == wait_last_s)) begin
                    state_d     = IDLE;
                    cnt_d       = 32'd0;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            WRAP_ISSUE: begin
                db_d        = other_line_cmd(line_q);
                rs_d        = 1'b0;
                line_d      = ~line_q;
                col_d       = 4'd0;
                wrap_pend_d = 1'b0;
                cnt_d       = 32'd0;
                state_d     = SETUP;
            end
            default: begin
                state_d = POR_WAIT;
                cnt_d   = 32'd0;
            end
        endcase
        // Outputs are registered from the next state so they align with it.
        e_d   = (state_d == E_HIGH);
        rdy_d = (state_d == IDLE) && init_done_d;
    end

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= POR_WAIT;
            cnt_q       <= 32'd0;
            init_idx_q  <= 2'd0;
            wrap_pend_q <= 1'b0;
            db_q        <= 8'h00;
            rs_q        <= 1'b0;
            e_q         <= 1'b0;
            rdy_q       <= 1'b0;
            init_done_q <= 1'b0;
            line_q      <= 1'b0;
            col_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_idx_q  <= init_idx_d;
            wrap_pend_q <= wrap_pend_d;
            db_q        <= db_d;
            rs_q        <= rs_d;
            e_q         <= e_d;
            rdy_q       <= rdy_d;
            init_done_q <= init_done_d;
            line_q      <= line_d;
            col_q       <= col_d;
        end
    end

    // A clear or newline request outranks a character offered in the same cycle.
    assign char_ready = rdy_q & ~clear_req & ~newline_req;
    assign busy       = ~rdy_q;
    assign init_done  = init_done_q;
    assign lcd_db     = db_q;
    assign lcd_rs     = rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_e      = e_q;
    assign cur_line   = line_q;
    assign cur_col    = col_q;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Self-checking bench for lcd_bus_driver with small timing parameters
// (POR 10, setup 2, E 3, command wait 5, clear wait 8).
module tb_lcd_bus_driver;

    localparam int K_CLR  = 0;
    localparam int K_NL   = 1;
    localparam int K_CHAR = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] char_in = 8'h00;
    logic       char_valid = 1'b0;
    logic       clear_req = 1'b0;
    logic       newline_req = 1'b0;
    logic       char_ready, init_done, busy, lcd_rs, lcd_rw, lcd_e, cur_line;
    logic [7:0] lcd_db;
    logic [3:0] cur_col;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Log of E pulses seen on the bus.
    logic [7:0] p_db[$];
    logic       p_rs[$];
    int         p_w[$];
    int         p_cyc[$];

    typedef struct {
        int         kind;
        logic [7:0] ch;
        logic [7:0] exp_db;
        logic       exp_rs;
        int         exp_busy;
        logic       exp_line;
        logic [3:0] exp_col;
    } vec_t;
    vec_t vecs[9];

    lcd_bus_driver #(
        .POR_WAIT_CYC(10), .SETUP_CYC(2), .E_PULSE_CYC(3),
        .CMD_WAIT_CYC(5), .CLR_WAIT_CYC(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(char_valid),
        .char_ready(char_ready), .clear_req(clear_req), .newline_req(newline_req),
        .init_done(init_done), .busy(busy), .lcd_db(lcd_db), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_e(lcd_e), .cur_line(cur_line), .cur_col(cur_col)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Bus monitor: records each E pulse (db, rs, width, start cycle).
    initial begin
        logic       e_prev;
        logic [7:0] hold_db;
        logic       hold_rs;
        int         cur_w;
        e_prev = 1'b0; hold_db = 8'h00; hold_rs = 1'b0; cur_w = 0;
        forever begin
            @(negedge clk);
            chk("rw_zero", 32'(lcd_rw), 32'd0);
            if (!rst_n) begin
                if (e_prev) p_w.push_back(cur_w);
                e_prev = 1'b0;
            end else if (lcd_e && !e_prev) begin
                p_db.push_back(lcd_db); p_rs.push_back(lcd_rs); p_cyc.push_back(cyc);
                hold_db = lcd_db; hold_rs = lcd_rs; cur_w = 1; e_prev = 1'b1;
            end else if (lcd_e) begin
                chk("db_stable", 32'({lcd_rs, lcd_db}), 32'({hold_rs, hold_db}));
                cur_w++;
            end else if (e_prev) begin
                p_w.push_back(cur_w);
                e_prev = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int g = 0;
        while (busy && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Releases reset and checks the init sequence and its timing.
    task automatic check_init();
        logic [7:0] icmd[4];
        int base, k;
        icmd[0] = 8'h38; icmd[1] = 8'h0C; icmd[2] = 8'h06; icmd[3] = 8'h01;
        @(negedge clk);
        base = p_db.size();
        rst_n = 1'b1;
        k = 0;
        while (k < 200) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (init_done) break;
            // Requests during init must be ignored.
            if (k == 5 || k == 30) begin
                clear_req = 1'b1; newline_req = 1'b1; char_valid = 1'b1; char_in = 8'h5A;
            end else begin
                clear_req = 1'b0; newline_req = 1'b0; char_valid = 1'b0;
            end
            if (k == 30) chk("ready_during_init", 32'(char_ready), 32'd0);
        end
        clear_req = 1'b0; newline_req = 1'b0; char_valid = 1'b0;
        chk("init_cycles", 32'(k), 32'd53);
        chk("ready_after_init", 32'(char_ready), 32'd1);
        chk("busy_after_init", 32'(busy), 32'd0);
        chk("init_pulses", 32'(p_db.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < p_w.size()) begin
                chk("init_db", 32'(p_db[base + i]), 32'(icmd[i]));
                chk("init_rs", 32'(p_rs[base + i]), 32'd0);
                chk("init_e_width", 32'(p_w[base + i]), 32'd3);
            end
        end
        chk("init_line", 32'(cur_line), 32'd0);
        chk("init_col", 32'(cur_col), 32'd0);
    endtask

    // Issues one request in IDLE; returns busy length and E start offset.
    task automatic run_txn(input int kind, input logic [7:0] ch,
                           output int busy_len, output int e_off);
        int acc, base;
        wait_idle();
        base = p_db.size();
        case (kind)
            K_CLR:   clear_req = 1'b1;
            K_NL:    newline_req = 1'b1;
            default: begin char_valid = 1'b1; char_in = ch; end
        endcase
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        clear_req = 1'b0; newline_req = 1'b0; char_valid = 1'b0;
        busy_len = 0;
        while (busy && busy_len < 200) begin
            busy_len++;
            @(negedge clk);
        end
        if (base < p_cyc.size()) e_off = p_cyc[base] - acc;
        else e_off = -1;
    endtask

    initial begin
        int bl, eo, base, k;
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bl, eo, base, k;
        vecs[0] = '{K_CHAR, 8'h41, 8'h41, 1'b1, 10, 1'b0, 4'd1};
        vecs[1] = '{K_CHAR, 8'h7A, 8'h7A, 1'b1, 10, 1'b0, 4'd2};
        vecs[2] = '{K_NL,   8'h00, 8'hC0, 1'b0, 10, 1'b1, 4'd0};
        vecs[3] = '{K_CHAR, 8'h30, 8'h30, 1'b1, 10, 1'b1, 4'd1};
        vecs[4] = '{K_NL,   8'h00, 8'h80, 1'b0, 10, 1'b0, 4'd0};
        vecs[5] = '{K_CLR,  8'h00, 8'h01, 1'b0, 13, 1'b0, 4'd0};
        vecs[6] = '{K_CHAR, 8'h21, 8'h21, 1'b1, 10, 1'b0, 4'd1};
        vecs[7] = '{K_NL,   8'h00, 8'hC0, 1'b0, 10, 1'b1, 4'd0};
        vecs[8] = '{K_CLR,  8'h00, 8'h01, 1'b0, 13, 1'b0, 4'd0};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_e", 32'(lcd_e), 32'd0);
        chk("rst_db", 32'(lcd_db), 32'd0);
        chk("rst_rs", 32'(lcd_rs), 32'd0);
        chk("rst_ready", 32'(char_ready), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_line", 32'(cur_line), 32'd0);
        chk("rst_col", 32'(cur_col), 32'd0);

        check_init();

        // Table-driven single transactions.
        for (int i = 0; i < 9; i++) begin
            base = p_db.size();
            run_txn(vecs[i].kind, vecs[i].ch, bl, eo);
            chk("vec_pulses", 32'(p_db.size() - base), 32'd1);
            if (base < p_w.size()) begin
                chk("vec_db", 32'(p_db[base]), 32'(vecs[i].exp_db));
                chk("vec_rs", 32'(p_rs[base]), 32'(vecs[i].exp_rs));
                chk("vec_e_width", 32'(p_w[base]), 32'd3);
            end
            chk("vec_e_offset", 32'(eo), 32'd2);
            chk("vec_busy_len", 32'(bl), 32'(vecs[i].exp_busy));
            chk("vec_line", 32'(cur_line), 32'(vecs[i].exp_line));
            chk("vec_col", 32'(cur_col), 32'(vecs[i].exp_col));
        end

        // Simultaneous clear, newline and char: clear wins, newline dropped.
        wait_idle();
        base = p_db.size();
        clear_req = 1'b1; newline_req = 1'b1; char_valid = 1'b1; char_in = 8'h42;
        #1;
        chk("ready_masked", 32'(char_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        clear_req = 1'b0; newline_req = 1'b0;
        k = 0;
        while (k < 100) begin
            #1;
            if (char_ready) break;
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        chk("pending_char_delay", 32'(k), 32'd13);
        @(posedge clk);
        @(negedge clk);
        char_valid = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("simul_pulses", 32'(p_db.size() - base), 32'd2);
        if (base + 1 < p_db.size()) begin
            chk("simul_first_db", 32'(p_db[base]), 32'h01);
            chk("simul_second_db", 32'(p_db[base + 1]), 32'h42);
            chk("simul_second_rs", 32'(p_rs[base + 1]), 32'd1);
        end
        chk("simul_line", 32'(cur_line), 32'd0);
        chk("simul_col", 32'(cur_col), 32'd1);

        // Newline, then a newline and a char offered during EXEC_WAIT.
        base = p_db.size();
        newline_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        newline_req = 1'b0;
        repeat (6) @(negedge clk);
        newline_req = 1'b1; char_valid = 1'b1; char_in = 8'h55;
        #1;
        chk("ready_while_busy", 32'(char_ready), 32'd0);
        @(negedge clk);
        newline_req = 1'b0; char_valid = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);
        chk("drop_pulses", 32'(p_db.size() - base), 32'd1);
        if (base < p_db.size()) chk("drop_db", 32'(p_db[base]), 32'hC0);
        chk("drop_line", 32'(cur_line), 32'd1);
        chk("drop_col", 32'(cur_col), 32'd0);

        // Sixteen characters on a cleared display.
        run_txn(K_CLR, 8'h00, bl, eo);
        base = p_db.size();
        for (int i = 0; i < 16; i++) begin
            run_txn(K_CHAR, 8'(8'h61 + i), bl, eo);
            if (i == 14) chk("col_before_last", 32'(cur_col), 32'd15);
        end
`ifdef LCD_AUTOWRAP_EN
        chk("last_char_busy", 32'(bl), 32'd20);
        chk("wrap_pulses", 32'(p_db.size() - base), 32'd17);
        if (base + 16 < p_db.size()) begin
            chk("wrap_last_data", 32'(p_db[base + 15]), 32'h70);
            chk("wrap_cmd_db", 32'(p_db[base + 16]), 32'hC0);
            chk("wrap_cmd_rs", 32'(p_rs[base + 16]), 32'd0);
        end
        chk("wrap_line", 32'(cur_line), 32'd1);
        chk("wrap_col", 32'(cur_col), 32'd0);
`else
        chk("last_char_busy", 32'(bl), 32'd10);
        chk("nowrap_pulses", 32'(p_db.size() - base), 32'd16);
        if (base + 15 < p_db.size()) begin
            chk("nowrap_last_data", 32'(p_db[base + 15]), 32'h70);
            chk("nowrap_last_rs", 32'(p_rs[base + 15]), 32'd1);
        end
        chk("nowrap_line", 32'(cur_line), 32'd0);
        chk("nowrap_col", 32'(cur_col), 32'd0);
`endif

        // Reset during E_HIGH.
        wait_idle();
        char_valid = 1'b1; char_in = 8'h58;
        @(posedge clk);
        @(negedge clk);
        char_valid = 1'b0;
        k = 0;
        while (!lcd_e && k < 10) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #2;
        chk("e_before_reset", 32'(lcd_e), 32'd1);
        chk("col_before_reset", 32'(cur_col), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_e", 32'(lcd_e), 32'd0);
        chk("async_rst_db", 32'(lcd_db), 32'd0);
        chk("async_rst_rs", 32'(lcd_rs), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd1);
        chk("async_rst_init_done", 32'(init_done), 32'd0);
        chk("async_rst_ready", 32'(char_ready), 32'd0);
        chk("async_rst_col", 32'(cur_col), 32'd0);
        chk("async_rst_line", 32'(cur_line), 32'd0);
        repeat (2) @(negedge clk);
        check_init();

        // Normal operation resumes from a clean cursor.
        run_txn(K_CHAR, 8'h41, bl, eo);
        chk("post_reset_busy", 32'(bl), 32'd10);
        chk("post_reset_col", 32'(cur_col), 32'd1);
        chk("post_reset_line", 32'(cur_line), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
